// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared widths and writeback record type for the register-file write path.
package rf_ctrl_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 2 ** ADDR_W;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, search starts one past ptr.
module rr_arbiter import rf_ctrl_pkg::*; #(
  parameter int N = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);
  int idx;
  logic found;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin RF writeback port sharing plus destination busy scoreboard.
// Define RF_WB_BYPASS_EN to forward the writeback-stage data and mask busy on a hit.
module rf_wb_arbiter import rf_ctrl_pkg::*; #(
  parameter int NREQ = 3,
  parameter int ADDR = ADDR_W,
  parameter int BUS_W = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ADDR-1:0]  req_addr,
  input  logic [NREQ*BUS_W-1:0] req_data,
  input  logic                  alloc_valid,
  input  logic [ADDR-1:0]       alloc_addr,
  output logic                  alloc_ready,
  input  logic [ADDR-1:0]       rs_addr,
  input  logic [ADDR-1:0]       rt_addr,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic                  rf_write,
  output logic [ADDR-1:0]       rf_rd_addr,
  output logic [BUS_W-1:0]      rf_rd_w_data,
  output logic                  rs_fwd_valid,
  output logic                  rt_fwd_valid,
  output logic [BUS_W-1:0]      fwd_data
);
  localparam int PW = $clog2(NREQ);
  localparam int NR = 1 << ADDR;
  logic [NREQ-1:0]  gnt;
  logic [PW-1:0]    gnt_idx, ptr_q;
  logic             wb_valid_q;
  logic [ADDR-1:0]  wb_addr_q;
  logic [BUS_W-1:0] wb_data_q;
  logic [NR-1:0]    busy_q, busy_d;
  rr_arbiter #(.N(NREQ)) u_arb (.req(req_valid), .ptr(ptr_q), .gnt(gnt), .gnt_idx(gnt_idx));
  assign req_ready = rst ? '0 : gnt;
  assign alloc_ready = !rst && (alloc_addr == '0 || !busy_q[alloc_addr]);
  assign rf_write = !rst && wb_valid_q && wb_addr_q != '0;
  assign rf_rd_addr = wb_addr_q;
  assign rf_rd_w_data = wb_data_q;
  // a clear and a new reservation of the same register: the reservation survives
  always_comb begin
    busy_d = busy_q;
    if (rf_write) busy_d[wb_addr_q] = 1'b0;
    if (alloc_valid && alloc_ready && alloc_addr != '0) busy_d[alloc_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PW'(NREQ - 1);
      wb_valid_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      wb_valid_q <= |gnt;
      if (|gnt) begin
        ptr_q <= gnt_idx;
        wb_addr_q <= req_addr[gnt_idx*ADDR +: ADDR];
        wb_data_q <= req_data[gnt_idx*BUS_W +: BUS_W];
      end
    end
  end
`ifdef RF_WB_BYPASS_EN
  assign rs_fwd_valid = rf_write && rf_rd_addr == rs_addr;
  assign rt_fwd_valid = rf_write && rf_rd_addr == rt_addr;
  assign fwd_data = wb_data_q;
  assign rs_busy = busy_q[rs_addr] && !rs_fwd_valid;
  assign rt_busy = busy_q[rt_addr] && !rt_fwd_valid;
`else
  assign rs_fwd_valid = 1'b0;
  assign rt_fwd_valid = 1'b0;
  assign fwd_data = '0;
  assign rs_busy = busy_q[rs_addr];
  assign rt_busy = busy_q[rt_addr];
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: per-cycle vector table plus a streaming round-robin sequence.
module tb_rf_wb_arbiter;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] req_valid, req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic alloc_valid, alloc_ready, rs_busy, rt_busy, rf_write, rs_fwd_valid, rt_fwd_valid;
  logic [4:0] alloc_addr, rs_addr, rt_addr, rf_rd_addr;
  logic [31:0] rf_rd_w_data, fwd_data;
  int n_cmp = 0, n_fail = 0, row = 0;

  rf_wb_arbiter dut (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .alloc_ready(alloc_ready), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy),
    .rt_busy(rt_busy), .rf_write(rf_write), .rf_rd_addr(rf_rd_addr), .rf_rd_w_data(rf_rd_w_data),
    .rs_fwd_valid(rs_fwd_valid), .rt_fwd_valid(rt_fwd_valid), .fwd_data(fwd_data));

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [2:0] vld; logic [4:0] a0, a1, a2; logic [31:0] d0, d1, d2;
    logic av; logic [4:0] aa, rs, rt;
    logic [2:0] rdy; logic ar, wr, wchk; logic [4:0] wa; logic [31:0] wd; logic rsb, rtb;
  } vec_t;

  function automatic vec_t mk(logic r, logic [2:0] v, logic [4:0] a0, a1, a2,
      logic [31:0] d0, d1, d2, logic av, logic [4:0] aa, rs, rt, logic [2:0] rdy,
      logic ar, wr, wchk, logic [4:0] wa, logic [31:0] wd, logic rsb, rtb);
    vec_t t;
    t.rst = r; t.vld = v; t.a0 = a0; t.a1 = a1; t.a2 = a2; t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.av = av; t.aa = aa; t.rs = rs; t.rt = rt; t.rdy = rdy; t.ar = ar; t.wr = wr;
    t.wchk = wchk; t.wa = wa; t.wd = wd; t.rsb = rsb; t.rtb = rtb;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    rst = t.rst; req_valid = t.vld; req_addr = {t.a2, t.a1, t.a0}; req_data = {t.d2, t.d1, t.d0};
    alloc_valid = t.av; alloc_addr = t.aa; rs_addr = t.rs; rt_addr = t.rt;
  endtask

  vec_t tbl[22];
  vec_t s;

  initial begin
    //            rst vld a0 a1 a2 d0 d1 d2 av aa rs rt | rdy ar wr wchk wa wd rsb rtb
    tbl[0]  = mk(1, 3'b111, 1, 2, 3, 'h11, 'h22, 'h33, 1, 5, 5, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = tbl[0];
    tbl[2]  = mk(0, 3'b111, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 0, 0, 3'b001, 1, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 3'b111, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 0, 0, 3'b010, 1, 1, 1, 1, 'h11, 0, 0);
    tbl[4]  = mk(0, 3'b111, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 0, 0, 3'b100, 1, 1, 1, 2, 'h22, 0, 0);
    tbl[5]  = mk(0, 3'b111, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 0, 0, 3'b001, 1, 1, 1, 3, 'h33, 0, 0);
    tbl[6]  = mk(0, 3'b000, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 0, 0, 3'b000, 1, 1, 1, 1, 'h11, 0, 0);
    tbl[7]  = mk(0, 3'b000, 1, 2, 3, 'h11, 'h22, 'h33, 1, 5, 5, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 3'b010, 1, 5, 3, 'h11, 'hDEADBEEF, 'h33, 1, 5, 5, 0, 3'b010, 0, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 3'b000, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 5, 0, 3'b000, 1, 1, 1, 5, 'hDEADBEEF, 1, 0);
    tbl[10] = mk(0, 3'b000, 1, 2, 3, 'h11, 'h22, 'h33, 0, 5, 5, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 3'b001, 0, 2, 3, 'hFFFFFFFF, 'h22, 'h33, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 3'b111, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 0, 0, 3'b010, 1, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 3'b000, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 0, 0, 3'b000, 1, 1, 1, 2, 'h22, 0, 0);
    tbl[14] = mk(0, 3'b100, 1, 2, 7, 'h11, 'h22, 'h77, 0, 7, 7, 0, 3'b100, 1, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 3'b000, 1, 2, 3, 'h11, 'h22, 'h33, 1, 7, 7, 7, 3'b000, 1, 1, 1, 7, 'h77, 0, 0);
    tbl[16] = mk(0, 3'b000, 1, 2, 3, 'h11, 'h22, 'h33, 0, 7, 7, 7, 3'b000, 0, 0, 0, 0, 0, 1, 1);
    tbl[17] = mk(0, 3'b010, 1, 4, 3, 'h11, 'h1234, 'h33, 1, 4, 0, 0, 3'b010, 1, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 3'b000, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 4, 3, 3'b000, 1, 1, 1, 4, 'h1234, 1, 0);
    tbl[19] = mk(0, 3'b001, 9, 2, 3, 'h99, 'h22, 'h33, 0, 0, 4, 0, 3'b001, 1, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(1, 3'b000, 1, 2, 3, 'h11, 'h22, 'h33, 1, 3, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 3'b111, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 7, 4, 3'b001, 1, 0, 1, 0, 0, 0, 0);
    drive(tbl[0]);
    @(posedge clk);
    for (int i = 0; i < 22; i++) begin
      row = i;
      #1 drive(tbl[i]);
      @(negedge clk);
      s = tbl[i];
      chk("req_ready", 32'(req_ready), 32'(s.rdy));
      chk("alloc_ready", 32'(alloc_ready), 32'(s.ar));
      chk("rf_write", 32'(rf_write), 32'(s.wr));
      if (s.wr || s.wchk) begin
        chk("rf_rd_addr", 32'(rf_rd_addr), 32'(s.wa));
        chk("rf_rd_w_data", rf_rd_w_data, s.wd);
      end
      chk("rs_fwd_valid", 32'(rs_fwd_valid), 32'(BYP && s.wr && s.wa == s.rs));
      chk("rt_fwd_valid", 32'(rt_fwd_valid), 32'(BYP && s.wr && s.wa == s.rt));
      if (s.wr || !BYP) chk("fwd_data", fwd_data, BYP ? s.wd : 32'h0);
      chk("rs_busy", 32'(rs_busy), 32'(s.rsb && !(BYP && s.wr && s.wa == s.rs)));
      chk("rt_busy", 32'(rt_busy), 32'(s.rtb && !(BYP && s.wr && s.wa == s.rt)));
      @(posedge clk);
    end
    // streaming: requester 0 was just granted, rotation continues 1,2,0 with one write per cycle
    for (int k = 0; k < 6; k++) begin
      row = 100 + k;
      #1 drive(tbl[21]);
      @(negedge clk);
      chk("rr_stream_ready", 32'(req_ready), 32'(3'b001 << ((k + 1) % 3)));
      chk("rr_stream_write", 32'(rf_write), 32'd1);
      chk("rr_stream_addr", 32'(rf_rd_addr), 32'(k % 3 + 1));
      @(posedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
